// File: rtl/ring_counter_pkg.sv
// Shared constants, state encoding and seed helper for the ring/Johnson counter.
// Optional checker macro used by the counter: RING_SELF_CORRECT_EN.
package ring_counter_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  typedef enum logic {
    S_SEED = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // The ring seed is a single 1 in bit 0; the Johnson seed is all zeros.
  // The result is MAX_WIDTH wide so the caller casts it down to its own width.
  function automatic logic [MAX_WIDTH-1:0] seed_pattern(input logic mode,
                                                        input int unsigned width);
    seed_pattern = '0;
    if (mode == MODE_RING && width != 0) begin
      seed_pattern[0] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/ring_legal_check.sv
// Combinational legality check of a counter pattern: ring must be one-hot,
// Johnson must contain at most one boundary between runs of equal bits.
module ring_legal_check
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic             mode,
  output logic             legal
);

  logic [WIDTH-2:0] edges;

  // Bit i of edges marks a 0/1 boundary between q[i] and q[i+1].
  assign edges = q[WIDTH-2:0] ^ q[WIDTH-1:1];

  always_comb begin
    if (mode == MODE_RING) begin
      legal = ($countones(q) == 1);
    end else begin
      legal = ($countones(edges) <= 1);
    end
  end

endmodule

// File: rtl/ring_johnson_counter.sv
// Ring / Johnson sequence generator with direction, enable, clear, load and wrap pulse.
// Define RING_SELF_CORRECT_EN to add the illegal-pattern checker that drives err_o.
module ring_johnson_counter
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic             dir_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] q_o,
  output logic             wrap_o,
  output logic             err_o
);

  if (WIDTH < 2 || WIDTH > int'(MAX_WIDTH)) begin : g_bad_width
    $error("ring_johnson_counter: WIDTH must be in 2..64");
  end

  state_e           state_q, state_d;
  logic             mode_q,  mode_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic             wrap_q,  wrap_d;
  logic             err_q,   err_d;

  logic [WIDTH-1:0] seed_run;
  logic [WIDTH-1:0] seed_new;
  logic [WIDTH-1:0] step_up;
  logic [WIDTH-1:0] step_dn;
  logic             fix_req;

  assign seed_run = WIDTH'(seed_pattern(mode_q, WIDTH));
  assign seed_new = WIDTH'(seed_pattern(mode_i, WIDTH));

  // The bit shifted back in is inverted in Johnson mode, straight in ring mode.
  assign step_up = {q_q[WIDTH-2:0], q_q[WIDTH-1] ^ mode_q};
  assign step_dn = {q_q[0] ^ mode_q, q_q[WIDTH-1:1]};

`ifdef RING_SELF_CORRECT_EN
  logic legal;

  ring_legal_check #(
    .WIDTH(WIDTH)
  ) u_legal (
    .q    (q_q),
    .mode (mode_q),
    .legal(legal)
  );

  assign fix_req = (state_q == S_RUN) && !legal;
`else
  assign fix_req = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_SEED;
      mode_q  <= MODE_RING;
      q_q     <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      q_q     <= q_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    if (clr_i) begin
      state_d = S_SEED;
    end else if (load_i) begin
      state_d = S_RUN;
    end else if (state_q == S_SEED && en_i) begin
      state_d = S_RUN;
    end
  end

  always_comb begin
    q_d    = q_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (clr_i) begin
      q_d = '0;
    end else if (load_i) begin
      q_d    = load_val_i;
      mode_d = mode_i;
    end else if (fix_req) begin
      q_d   = seed_run;
      err_d = 1'b1;
    end else if (en_i) begin
      if (state_q == S_SEED) begin
        // Mode is latched here; later mode_i changes are ignored until re-seed/load.
        mode_d = mode_i;
        q_d    = seed_new;
      end else begin
        q_d    = dir_i ? step_dn : step_up;
        wrap_d = (q_d == seed_run);
      end
    end
  end

  assign q_o    = q_q;
  assign wrap_o = wrap_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Scoreboard bench for ring_johnson_counter (WIDTH = 4): directed test-plan
// sequences followed by random stimulus against a rotation-based reference model.
module tb_ring_johnson_counter;

  localparam int W = 4;
`ifdef RING_SELF_CORRECT_EN
  localparam bit SELF_CORRECT = 1'b1;
`else
  localparam bit SELF_CORRECT = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic         wrap;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         clr_i = 1'b0;
  logic         en_i = 1'b0;
  logic         mode_i = 1'b0;
  logic         dir_i = 1'b0;
  logic         load_i = 1'b0;
  logic [W-1:0] load_val_i = '0;
  logic [W-1:0] q_o;
  logic         wrap_o;
  logic         err_o;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t exp_q[$];

  // Reference model state
  logic [W-1:0] m_q = '0;
  logic         m_mode = 1'b0;
  logic         m_run = 1'b0;
  logic         m_wrap = 1'b0;
  logic         m_err = 1'b0;

  ring_johnson_counter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (clr_i),
    .en_i      (en_i),
    .mode_i    (mode_i),
    .dir_i     (dir_i),
    .load_i    (load_i),
    .load_val_i(load_val_i),
    .q_o       (q_o),
    .wrap_o    (wrap_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] seed_of(input logic mode);
    return mode ? '0 : W'(1);
  endfunction

  function automatic logic [W-1:0] rotate(input logic [W-1:0] v, input logic toward_lsb);
    if (toward_lsb) return (v >> 1) | (v << (W-1));
    else            return (v << 1) | (v >> (W-1));
  endfunction

  // Johnson step = plain rotation with the bit that wrapped around inverted.
  function automatic logic [W-1:0] advance(input logic [W-1:0] v, input logic mode,
                                           input logic toward_lsb);
    logic [W-1:0] r;
    r = rotate(v, toward_lsb);
    if (mode) begin
      if (toward_lsb) r[W-1] = ~r[W-1];
      else            r[0]   = ~r[0];
    end
    return r;
  endfunction

  function automatic bit is_legal(input logic [W-1:0] v, input logic mode);
    int ones = 0;
    int bounds = 0;
    for (int i = 0; i < W; i++) ones += int'(v[i]);
    for (int i = 0; i < W-1; i++) if (v[i] != v[i+1]) bounds++;
    return mode ? (bounds <= 1) : (ones == 1);
  endfunction

  task automatic model_edge(input logic clr, input logic en, input logic mode,
                            input logic dir, input logic load, input logic [W-1:0] lv);
    m_wrap = 1'b0;
    m_err  = 1'b0;
    if (clr) begin
      m_q   = '0;
      m_run = 1'b0;
    end else if (load) begin
      m_q    = lv;
      m_mode = mode;
      m_run  = 1'b1;
    end else if (SELF_CORRECT && m_run && !is_legal(m_q, m_mode)) begin
      m_q   = seed_of(m_mode);
      m_err = 1'b1;
    end else if (en) begin
      if (!m_run) begin
        m_mode = mode;
        m_q    = seed_of(mode);
        m_run  = 1'b1;
      end else begin
        m_q    = advance(m_q, m_mode, dir);
        m_wrap = (m_q == seed_of(m_mode));
      end
    end
  endtask

  // Drive one edge's inputs, then record the model's expected post-edge outputs.
  task automatic step(input logic clr, input logic en, input logic mode,
                      input logic dir, input logic load, input logic [W-1:0] lv);
    clr_i      = clr;
    en_i       = en;
    mode_i     = mode;
    dir_i      = dir;
    load_i     = load;
    load_val_i = lv;
    @(posedge clk);
    model_edge(clr, en, mode, dir, load, lv);
    exp_q.push_back('{q: m_q, wrap: m_wrap, err: m_err});
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_q", 64'(q_o), 64'(e.q));
        check("sb_wrap", 64'(wrap_o), 64'(e.wrap));
        check("sb_err", 64'(err_o), 64'(e.err));
      end
    end
  end

  initial begin : stimulus
    logic r_clr, r_load, r_en, r_mode, r_dir;
    logic [W-1:0] r_val;

    #2;
    check("reset_q", 64'(q_o), 64'h0);
    check("reset_wrap", 64'(wrap_o), 64'h0);
    check("reset_err", 64'(err_o), 64'h0);
    #10 reset = 1'b1;

    // Ring, toward MSB: 0001 0010 0100 1000 0001(wrap)
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, '0);
    check("ring_period_q", 64'(q_o), 64'h1);
    check("ring_period_wrap", 64'(wrap_o), 64'h1);

    // Johnson, toward MSB: seed then 8 steps back to 0000 with wrap
    step(1, 0, 0, 0, 0, '0);
    for (int i = 0; i < 9; i++) step(0, 1, 1, 0, 0, '0);
    check("john_up_q", 64'(q_o), 64'h0);
    check("john_up_wrap", 64'(wrap_o), 64'h1);

    // Johnson, toward LSB, then reverse direction from 0000
    step(1, 0, 0, 0, 0, '0);
    for (int i = 0; i < 9; i++) step(0, 1, 1, 1, 0, '0);
    step(0, 1, 1, 0, 0, '0);
    check("john_reverse_q", 64'(q_o), 64'h1);

    // Illegal ring pattern 0101 loaded, then one enabled step
    step(0, 1, 0, 0, 1, 4'b0101);
    step(0, 1, 0, 0, 0, '0);
    check("illegal_load_q", 64'(q_o), SELF_CORRECT ? 64'h1 : 64'hA);
    check("illegal_load_err", 64'(err_o), SELF_CORRECT ? 64'h1 : 64'h0);

    // clr beats load; then hold in S_SEED
    step(1, 1, 0, 0, 1, 4'b1111);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 4'b0110);
    check("clr_hold_q", 64'(q_o), 64'h0);

    // Reset between edges while running at 0100
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, '0);
    #2 reset = 1'b0;
    #1;
    check("midrun_reset_q", 64'(q_o), 64'h0);
    check("midrun_reset_err", 64'(err_o), 64'h0);
    m_q = '0; m_mode = 1'b0; m_run = 1'b0;
    #10 reset = 1'b1;
    step(0, 1, 0, 0, 0, '0);
    check("after_reset_seed", 64'(q_o), 64'h1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      r_clr  = ($urandom_range(31) == 0);
      r_load = ($urandom_range(15) == 0);
      r_en   = ($urandom_range(3) != 0);
      r_mode = 1'($urandom_range(1));
      r_dir  = 1'($urandom_range(1));
      r_val  = W'($urandom);
      step(r_clr, r_en, r_mode, r_dir, r_load, r_val);
    end

    step(0, 0, 0, 0, 0, '0);
    #20;
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ring_johnson_counter.md
Name: ring_johnson_counter

Overview:
- Parametrised successor to the n-bit ring counter.
- Selectable ring (one-hot rotate) or Johnson (twisted-ring) sequence, with:
  - runtime shift direction;
  - count enable;
  - synchronous clear;
  - parallel load;
  - a wrap pulse marking each full period.
- Used as a phase/sequence generator driving one-hot enables in downstream datapaths.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-low.
- clr_i  input  1  synchronous clear back to SEED state.
- en_i  input  1  advance one step per enabled clock.
- mode_i  input  1  0 = ring, 1 = Johnson; sampled only when seeding or loading.
- dir_i  input  1  0 = shift toward MSB, 1 = shift toward LSB; sampled every step.
- load_i  input  1  parallel load request.
- load_val_i  input  WIDTH  value loaded on load_i.
- q_o  output  WIDTH  counter state, registered.
- wrap_o  output  1  registered one-cycle pulse: a shift step produced the mode seed pattern.
- err_o  output  1  registered one-cycle pulse: illegal pattern corrected (0 when feature absent).

Behaviour:
- Reset (reset = 0, asynchronous, no clock needed):
  - q_o = 0, wrap_o = 0, err_o = 0.
  - FSM = S_SEED, mode_q = 0.
- FSM states: S_SEED, S_RUN.
- Per-edge priority: clr_i > load_i > correction (feature only) > en_i.
- clr_i:
  - q_o <= 0; FSM -> S_SEED; wrap_o and err_o <= 0.
- load_i:
  - q_o <= load_val_i; mode_q <= mode_i; FSM -> S_RUN.
  - wrap_o <= 0; err_o <= 0.
  - Load is accepted in either state. No legality check is made at load time.
- S_SEED with en_i = 1:
  - mode_q <= mode_i; FSM -> S_RUN.
  - q_o <= seed: ring = 0..01, Johnson = 0..00.
  - wrap_o <= 0 (a seed load is not a wrap).
- S_SEED with en_i = 0: hold.
- S_RUN with en_i = 1, one step:
  - Ring, dir 0: q <= {q[W-2:0], q[W-1]}.
  - Ring, dir 1: q <= {q[0], q[W-1:1]}.
  - Johnson, dir 0: q <= {q[W-2:0], ~q[W-1]}.
  - Johnson, dir 1: q <= {~q[0], q[W-1:1]}.
- S_RUN with en_i = 0: q_o holds; wrap_o <= 0.
- mode_i changes during S_RUN are ignored until the next clr_i/seed or load_i.
- wrap_o <= 1 exactly when a step's next q equals the mode_q seed.
  - Periods: ring = WIDTH steps, Johnson = 2*WIDTH steps, in either direction.
- dir_i may change on any step; the sequence reverses from the current q with no glitch cycle.
- Reset asserted mid-run: immediate return to reset values. The sequence restarts from S_SEED after release.

Optional Feature:
- Macro: RING_SELF_CORRECT_EN.
- Defined:
  - In S_RUN, each clock, the current q is checked for legality, independent of en_i.
  - Ring is legal iff popcount == 1.
  - Johnson is legal iff there is at most one i in 0..W-2 with q[i] != q[i+1].
  - Illegal (and no clr_i/load_i this edge): q_o <= mode seed, err_o <= 1, wrap_o <= 0, state stays S_RUN.
- Undefined:
  - No checker logic; err_o tied 0.
  - Illegal patterns shift per the normal rules indefinitely.

Decomposition:
- Package ring_counter_pkg holds:
  - mode constants MODE_RING = 1'b0, MODE_JOHNSON = 1'b1;
  - state encoding S_SEED = 1'b0, S_RUN = 1'b1;
  - function seed_pattern(mode, width).
- One sub-module, ring_legal_check:
  - Combinational; WIDTH parameter; inputs q and mode; output legal.
  - Instantiated only under RING_SELF_CORRECT_EN.

Test Plan (WIDTH = 4):
- Ring, dir 0: reset release, en = 1, mode = 0, dir = 0 -> q: 0000, 0001, 0010, 0100, 1000, 0001. wrap_o = 1 only with the second 0001.
- Johnson, dir 0: mode = 1, dir = 0 from reset -> q: 0000 (seed), 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000. wrap_o = 1 on the final 0000.
- Johnson, dir 1 from seed -> q: 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000 (wrap). Then toggle dir to 0 -> 0001.
- Load 0101 in ring mode, en = 1:
  - With RING_SELF_CORRECT_EN: next edge q = 0001, err_o = 1 for one cycle.
  - Without it: q = 1010, err_o = 0.
- Precedence and hold: clr_i and load_i asserted together -> q = 0000, FSM in S_SEED. en = 0 for 3 cycles -> q unchanged, wrap_o = 0.
- Reset mid-run at q = 0100, asserted between clock edges -> q_o = 0000 and err_o = 0 before the next edge. After release, the first enabled edge gives the ring seed 0001.
